// File: rtl/iobus_arb.sv
// iobus_arb: two-port arbiter and request/done/release sequencer for the PDS I/O bus master.
// Optional IOREQ watchdog is compiled in by defining IOARB_WDT_EN.
module iobus_arb #(
    parameter int unsigned RR         = 1,
    parameter int unsigned WDT_CYCLES = 255
) (
    input  logic       C16M,
    input  logic       nRES,
    input  logic       R0REQ,
    input  logic       R0RW,
    input  logic       R0LDS,
    input  logic       R0UDS,
    output logic       R0DONE,
    input  logic       R1REQ,
    input  logic       R1RW,
    input  logic       R1LDS,
    input  logic       R1UDS,
    output logic       R1DONE,
    output logic       IOREQ,
    output logic       IORW,
    output logic       IOLDS,
    output logic       IOUDS,
    input  logic       IOACT,
    input  logic       IODONE,
    output logic       ASEL,
    output logic [1:0] GNT,
    output logic       TMO
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StRel  = 2'd2;

    logic [1:0] state_q, state_d;
    logic       ioreq_q, ioreq_d;
    logic [2:0] attr_q, attr_d;     // {rw, lds, uds}
    logic       asel_q, asel_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic       last_q, last_d;
    logic       both_req;
    logic       win;
    logic       wdt_hit;

`ifdef IOARB_WDT_EN
    localparam logic [7:0] WdtLast = 8'(WDT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;

    assign wdt_hit = (cnt_q == WdtLast);
    assign TMO     = tmo_q;

    // Counter sits at zero in IDLE, so it is cleared on every entry to REQ.
    always_comb begin
        cnt_d = cnt_q;
        tmo_d = 1'b0;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StReq) begin
            cnt_d = cnt_q + 8'd1;
            tmo_d = wdt_hit && !IODONE;
        end
    end

    always_ff @(posedge C16M or negedge nRES) begin
        if (!nRES) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_wdt_cfg;
    assign unused_wdt_cfg = ^WDT_CYCLES;
    assign wdt_hit        = 1'b0;
    assign TMO            = 1'b0;
`endif

    assign both_req = R0REQ & R1REQ;
    assign win      = both_req ? ((RR != 0) ? ~last_q : 1'b0) : R1REQ;

    always_comb begin
        state_d = state_q;
        ioreq_d = ioreq_q;
        attr_d  = attr_q;
        asel_d  = asel_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (R0REQ || R1REQ) begin
                    ioreq_d = 1'b1;
                    attr_d  = win ? {R1RW, R1LDS, R1UDS} : {R0RW, R0LDS, R0UDS};
                    asel_d  = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (IODONE || wdt_hit) begin
                    ioreq_d = 1'b0;
                    done_d  = gnt_q;
                    state_d = StRel;
                end
            end
            StRel: begin
                // Release only once the bus master has fully gone idle.
                if (!IOACT && !IODONE) begin
                    gnt_d   = 2'b00;
                    state_d = StIdle;
                end
            end
            default: begin
                ioreq_d = 1'b0;
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge C16M or negedge nRES) begin
        if (!nRES) begin
            state_q <= StIdle;
            ioreq_q <= 1'b0;
            attr_q  <= 3'b100;
            asel_q  <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ioreq_q <= ioreq_d;
            attr_q  <= attr_d;
            asel_q  <= asel_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign IOREQ  = ioreq_q;
    assign IORW   = attr_q[2];
    assign IOLDS  = attr_q[1];
    assign IOUDS  = attr_q[0];
    assign ASEL   = asel_q;
    assign GNT    = gnt_q;
    assign R0DONE = done_q[0];
    assign R1DONE = done_q[1];

endmodule

// File: tb/tb_iobus_arb.sv
// tb_iobus_arb: drives a round-robin and a fixed-priority iobus_arb from shared inputs and
// checks both against a transaction-level model of grants, attributes and handshake timing.
module tb_iobus_arb;

    logic C16M = 1'b0;
    logic nRES;
    logic R0REQ, R0RW, R0LDS, R0UDS;
    logic R1REQ, R1RW, R1LDS, R1UDS;
    logic IOACT, IODONE;

    logic       r0done_rr, r1done_rr, ioreq_rr, iorw_rr, iolds_rr, iouds_rr, asel_rr, tmo_rr;
    logic [1:0] gnt_rr;
    logic       r0done_fp, r1done_fp, ioreq_fp, iorw_fp, iolds_fp, iouds_fp, asel_fp, tmo_fp;
    logic [1:0] gnt_fp;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: last round-robin winner, and each DUT's held attributes / owner.
    logic       lw_m;
    logic [2:0] at_rr_m, at_fp_m;
    logic       asel_rr_m, asel_fp_m;

    always #5 C16M = ~C16M;

    iobus_arb #(.RR(1), .WDT_CYCLES(16)) u_rr (
        .C16M(C16M), .nRES(nRES),
        .R0REQ(R0REQ), .R0RW(R0RW), .R0LDS(R0LDS), .R0UDS(R0UDS), .R0DONE(r0done_rr),
        .R1REQ(R1REQ), .R1RW(R1RW), .R1LDS(R1LDS), .R1UDS(R1UDS), .R1DONE(r1done_rr),
        .IOREQ(ioreq_rr), .IORW(iorw_rr), .IOLDS(iolds_rr), .IOUDS(iouds_rr),
        .IOACT(IOACT), .IODONE(IODONE), .ASEL(asel_rr), .GNT(gnt_rr), .TMO(tmo_rr)
    );

    iobus_arb #(.RR(0), .WDT_CYCLES(16)) u_fp (
        .C16M(C16M), .nRES(nRES),
        .R0REQ(R0REQ), .R0RW(R0RW), .R0LDS(R0LDS), .R0UDS(R0UDS), .R0DONE(r0done_fp),
        .R1REQ(R1REQ), .R1RW(R1RW), .R1LDS(R1LDS), .R1UDS(R1UDS), .R1DONE(r1done_fp),
        .IOREQ(ioreq_fp), .IORW(iorw_fp), .IOLDS(iolds_fp), .IOUDS(iouds_fp),
        .IOACT(IOACT), .IODONE(IODONE), .ASEL(asel_fp), .GNT(gnt_fp), .TMO(tmo_fp)
    );

    function automatic logic [1:0] oh(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [9:0] obs_rr();
        return {ioreq_rr, iorw_rr, iolds_rr, iouds_rr, asel_rr, gnt_rr, r1done_rr, r0done_rr,
                tmo_rr};
    endfunction

    function automatic logic [9:0] obs_fp();
        return {ioreq_fp, iorw_fp, iolds_fp, iouds_fp, asel_fp, gnt_fp, r1done_fp, r0done_fp,
                tmo_fp};
    endfunction

    task automatic tick();
        @(posedge C16M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (IOREQ RW LDS UDS ASEL GNT[1:0] DONE[1:0] TMO)",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ioreq, input logic gnt_on,
                             input logic done_on, input logic tmo);
        chk($sformatf("%s/rr", tag), obs_rr(),
            {ioreq, at_rr_m, asel_rr_m, gnt_on ? oh(asel_rr_m) : 2'b00,
             done_on ? oh(asel_rr_m) : 2'b00, tmo});
        chk($sformatf("%s/fp", tag), obs_fp(),
            {ioreq, at_fp_m, asel_fp_m, gnt_on ? oh(asel_fp_m) : 2'b00,
             done_on ? oh(asel_fp_m) : 2'b00, tmo});
    endtask

    task automatic reset_model();
        lw_m      = 1'b1;
        at_rr_m   = 3'b100;
        at_fp_m   = 3'b100;
        asel_rr_m = 1'b0;
        asel_fp_m = 1'b0;
    endtask

    // One complete transaction starting from IDLE with IOACT/IODONE low.
    task automatic txn(input logic [1:0] pat, input logic [2:0] a0, input logic [2:0] a1,
                       input int act_dly, input int done_dly, input int rel_act,
                       input int rel_done, input bit wd);
        logic w_rr, w_fp;
        int   k;
        R0REQ = pat[0];
        R1REQ = pat[1];
        {R0RW, R0LDS, R0UDS} = a0;
        {R1RW, R1LDS, R1UDS} = a1;
        IOACT  = 1'b0;
        IODONE = 1'b0;
        w_rr = (pat == 2'b11) ? ~lw_m : pat[1];
        w_fp = pat[0] ? 1'b0 : 1'b1;
        lw_m      = w_rr;
        asel_rr_m = w_rr;
        asel_fp_m = w_fp;
        at_rr_m   = w_rr ? a1 : a0;
        at_fp_m   = w_fp ? a1 : a0;
        tick();
        chk_state("grant", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < done_dly; i++) begin
            IOACT = (i >= act_dly);
            {R0RW, R0LDS, R0UDS} = 3'($urandom);
            {R1RW, R1LDS, R1UDS} = 3'($urandom);
            if (wd && i == 0 && pat != 2'b11) begin
                R0REQ = 1'b0;
                R1REQ = 1'b0;
            end
            tick();
            chk_state("req_hold", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        IOACT  = 1'b1;
        IODONE = 1'b1;
        tick();
        chk_state("done", 1'b0, 1'b1, 1'b1, 1'b0);
        if (pat != 2'b11) begin
            R0REQ = 1'b0;
            R1REQ = 1'b0;
        end
        k = (rel_act > rel_done) ? rel_act : rel_done;
        for (int j = 0; j < k; j++) begin
            IOACT  = (j < rel_act);
            IODONE = (j < rel_done);
            tick();
            chk_state("rel_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        IOACT  = 1'b0;
        IODONE = 1'b0;
        tick();
        chk_state("rel_exit", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        nRES   = 1'b0;
        R0REQ  = 1'b0; R0RW = 1'b0; R0LDS = 1'b0; R0UDS = 1'b0;
        R1REQ  = 1'b0; R1RW = 1'b0; R1LDS = 1'b0; R1UDS = 1'b0;
        IOACT  = 1'b0;
        IODONE = 1'b0;
        reset_model();
        tick();
        tick();
        chk_state("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        nRES = 1'b1;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Single port-0 read: IOACT after 3 cycles, IODONE after 10.
        txn(2'b01, 3'b110, 3'b000, 3, 10, 1, 0, 1'b0);

        // Continuous contention: rr alternates, fp always port 0.
        for (int i = 0; i < 4; i++) begin
            txn(2'b11, 3'($urandom), 3'($urandom), 1, 4, 1, 1, 1'b0);
        end

        // Port-1 write with attributes churned and request withdrawn during REQ.
        txn(2'b10, 3'b000, 3'b011, 0, 5, 0, 1, 1'b1);

        // Release hold: IODONE stays high 3 cycles after IOACT falls.
        txn(2'b11, 3'b101, 3'b010, 1, 4, 1, 4, 1'b0);

`ifdef IOARB_WDT_EN
        R0REQ = 1'b1;
        R1REQ = 1'b0;
        {R0RW, R0LDS, R0UDS} = 3'b111;
        IOACT  = 1'b0;
        IODONE = 1'b0;
        lw_m = 1'b0; asel_rr_m = 1'b0; asel_fp_m = 1'b0;
        at_rr_m = 3'b111; at_fp_m = 3'b111;
        tick();
        chk_state("wdt_grant", 1'b1, 1'b1, 1'b0, 1'b0);
        R0REQ = 1'b0;
        for (int i = 0; i < 15; i++) begin
            IOACT = 1'b1;
            tick();
            chk_state("wdt_wait", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk_state("wdt_tmo", 1'b0, 1'b1, 1'b1, 1'b1);
        IOACT = 1'b0;
        tick();
        chk_state("wdt_rel", 1'b0, 1'b0, 1'b0, 1'b0);
`else
        // Without the watchdog REQ waits well past 16 cycles.
        txn(2'b01, 3'b111, 3'b000, 2, 20, 0, 0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [1:0] pat;
            int         act;
            pat = 2'($urandom_range(1, 3));
            act = $urandom_range(0, 3);
            txn(pat, 3'($urandom), 3'($urandom), act, act + 1 + $urandom_range(0, 8),
                $urandom_range(0, 2), $urandom_range(0, 3),
                (pat != 2'b11) && ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of REQ.
        R0REQ = 1'b1;
        R1REQ = 1'b0;
        {R0RW, R0LDS, R0UDS} = 3'b011;
        lw_m = 1'b0; asel_rr_m = 1'b0; asel_fp_m = 1'b0;
        at_rr_m = 3'b011; at_fp_m = 3'b011;
        tick();
        chk_state("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        IOACT = 1'b1;
        tick();
        #3;
        nRES = 1'b0;
        #1;
        reset_model();
        chk_state("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        R0REQ  = 1'b0;
        IOACT  = 1'b0;
        IODONE = 1'b1;
        tick();
        chk_state("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
        IODONE = 1'b0;
        nRES   = 1'b1;
        tick();
        chk_state("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Post-reset tie goes to port 0 on both arbiters.
        txn(2'b11, 3'b100, 3'b001, 0, 2, 0, 0, 1'b0);
        txn(2'b11, 3'b010, 3'b111, 0, 2, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
